run_ctrl: RTL and testbench
===========================

# run_ctrl

Run controller that sequences one program execution of the 9-bit single-cycle core: it owns the `req`/`done` host handshake, holds the core in reset before launch, detects halt by program-counter match, and counts run cycles. It also arbitrates the single data-memory port between the host (operand preload, result readback) and the core (during the run). It sits between the host-facing pins and `PC`/`dat_mem` inside the top level.

## Interface
- `D`, 10, program counter width
- `HALT_PC`, 128, PC value that marks program end
- `RST_CYC`, 2, cycles `core_rst` is held in START (1..15)
- `WDOG_LIMIT`, 16'hFFF0, run-cycle limit for the watchdog

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `req`  in  1  host run request, level
- `prog_ctr`  in  D  core program counter
- `host_we`  in  1  host memory write strobe
- `host_addr`  in  8  host memory address
- `host_wdat`  in  8  host write data
- `host_rdat`  out  8  memory read data to host (`mem_rdat` passthrough)
- `host_gnt`  out  1  host currently owns memory port
- `core_we`, `core_addr`[8], `core_wdat`[8]  in  core memory request
- `mem_we`, `mem_addr`[8], `mem_wdat`[8]  out  to `dat_mem`
- `mem_rdat`  in  8  from `dat_mem`
- `core_rst`  out  1  active-high reset to core
- `busy`  out  1  START or RUN
- `done`  out  1  run finished
- `timeout`  out  1  run ended by watchdog
- `cycle_cnt`  out  16  cycles spent in RUN

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE: `host_gnt`=1, `core_rst`=1. `req`=1 -> START; clear `cycle_cnt`, `timeout`, load reset counter with `RST_CYC`-1.
- START: `core_rst`=1, `host_gnt`=0, `mem_we`=0. Decrement reset counter; at 0 -> RUN.
- RUN: `core_rst`=0; memory port driven by core; `cycle_cnt` += 1 per cycle, saturating at 16'hFFFF. `prog_ctr`==`HALT_PC` -> DONE. Watchdog hit -> DONE with `timeout`=1.
- DONE: `done`=1, `core_rst`=1, `host_gnt`=1, `cycle_cnt`/`timeout` frozen. `req`=0 -> IDLE.
- `req` falling in START or RUN is ignored; run always completes.
- `req` held high in DONE: stays in DONE (no auto-restart).
- Halt and watchdog in same cycle: halt wins, `timeout`=0.
- Port mux: RUN selects `core_*`; IDLE/DONE select `host_*`; START forces `mem_we`=0, address from host.
- `host_we` while `host_gnt`=0: dropped, never queued.

## Timing
- Reset (`reset`=0 at edge): state IDLE, `core_rst`=1, `busy`=0, `done`=0, `timeout`=0, `cycle_cnt`=0, `host_gnt`=1. Reset mid-run aborts immediately; no `done`.
- `req` sampled at edge N in IDLE -> `busy`=1 from N+1; RUN from N+1+`RST_CYC`.
- Halt seen at RUN cycle edge M -> `done`=1 from M+1; `cycle_cnt` includes cycle M.
- All outputs except the memory mux and `host_rdat` are registered; mux is combinational from registered state.
- `req`=0 at edge in DONE -> IDLE, `done`=0 next cycle.

## Configuration
- `RUN_CTRL_WDOG_EN` defined: watchdog active; `cycle_cnt`==`WDOG_LIMIT` in RUN ends the run with `timeout`=1.
- Undefined: no watchdog logic; run ends only on halt; `timeout` tied 0; `cycle_cnt` still saturates.

## Structure
- `run_ctrl_pkg`: state enum `run_state_t`, default `HALT_PC`, `WDOG_LIMIT`, counter width constant.
- One sub-module `mem_port_mux`: combinational select of host/core memory signals by state, including `mem_we` gating.
- FSM, reset counter, cycle counter in `run_ctrl`.

## Test plan
- Reset mid-RUN (`cycle_cnt`=20) -> next cycle IDLE, `core_rst`=1, `cycle_cnt`=0, `done`=0.
- Host writes 8'hA5 to addr 8'h10 in IDLE, pulse `req`, `prog_ctr` reaches 128 after 50 RUN cycles -> `done`=1, `cycle_cnt`=50, `timeout`=0; `core_rst` high exactly 2 cycles after START entry.
- `host_we`=1 to addr 8'h10 during RUN -> `mem_we` follows `core_we` only; addr 8'h10 unchanged on readback.
- `RUN_CTRL_WDOG_EN`, `WDOG_LIMIT`=100, PC never 128 -> `done`=1, `timeout`=1, `cycle_cnt`=100.
- Halt and watchdog coincide at cycle 100 -> `timeout`=0; `req` held high in DONE keeps `done`=1; `req`=0 -> IDLE next cycle.
- `req` dropped during START -> run still completes to DONE.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run controller slice.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DONE
    } run_state_t;

    localparam int               CNT_W          = 16;
    localparam int               HALT_PC_DEF    = 128;
    localparam logic [CNT_W-1:0] WDOG_LIMIT_DEF = 16'hFFF0;

    // Run-cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Data-memory port arbitration: the core owns the port in RUN, the host otherwise.
// START keeps the host address but suppresses every write.
module mem_port_mux
    import run_ctrl_pkg::*;
(
    input  run_state_t  state,
    input  logic        host_we,
    input  logic [7:0]  host_addr,
    input  logic [7:0]  host_wdat,
    input  logic        core_we,
    input  logic [7:0]  core_addr,
    input  logic [7:0]  core_wdat,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdat
);

    always_comb begin
        mem_we   = host_we;
        mem_addr = host_addr;
        mem_wdat = host_wdat;
        case (state)
            ST_RUN: begin
                mem_we   = core_we;
                mem_addr = core_addr;
                mem_wdat = core_wdat;
            end
            ST_START: mem_we = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/run_ctrl.sv
// Sequences one program run of the core: req/done handshake, core reset, halt detect, cycle count.
// Optional watchdog is compiled in with `define RUN_CTRL_WDOG_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int               D          = 10,
    parameter logic [D-1:0]     HALT_PC    = D'(HALT_PC_DEF),
    parameter int               RST_CYC    = 2,
    parameter logic [CNT_W-1:0] WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [D-1:0]     prog_ctr,
    input  logic             host_we,
    input  logic [7:0]       host_addr,
    input  logic [7:0]       host_wdat,
    output logic [7:0]       host_rdat,
    output logic             host_gnt,
    input  logic             core_we,
    input  logic [7:0]       core_addr,
    input  logic [7:0]       core_wdat,
    output logic             mem_we,
    output logic [7:0]       mem_addr,
    output logic [7:0]       mem_wdat,
    input  logic [7:0]       mem_rdat,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt
);

    run_state_t       state;
    logic [3:0]       rst_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             halt_hit;
    logic             wdog_hit;

`ifdef RUN_CTRL_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
    logic timeout_q;
    assign timeout = timeout_q;
`else
    localparam bit WDOG_EN = 1'b0;
    assign timeout = 1'b0;
`endif

    assign cnt_next = sat_inc(cycle_cnt);
    assign halt_hit = (prog_ctr == HALT_PC);
    // Compared against the incremented value so the final count equals the limit.
    assign wdog_hit = WDOG_EN && (cnt_next == WDOG_LIMIT);
    assign host_rdat = mem_rdat;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            core_rst  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            host_gnt  <= 1'b1;
`ifdef RUN_CTRL_WDOG_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state     <= ST_START;
                        cycle_cnt <= '0;
                        rst_cnt   <= 4'(RST_CYC - 1);
                        busy      <= 1'b1;
                        host_gnt  <= 1'b0;
`ifdef RUN_CTRL_WDOG_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (rst_cnt == 4'd0) begin
                        state    <= ST_RUN;
                        core_rst <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt - 4'd1;
                    end
                end
                ST_RUN: begin
                    cycle_cnt <= cnt_next;
                    if (halt_hit || wdog_hit) begin
                        state    <= ST_DONE;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        host_gnt <= 1'b1;
`ifdef RUN_CTRL_WDOG_EN
                        timeout_q <= !halt_hit;
`endif
                    end
                end
                ST_DONE: begin
                    if (!req) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_port_mux u_mux (
        .state     (state),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdat (host_wdat),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdat (core_wdat),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdat  (mem_wdat)
    );

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed steps plus randomized runs against a run-level model.
module tb_run_ctrl;
    localparam int LIMIT   = 100;
    localparam int RST_CYC = 2;
`ifdef RUN_CTRL_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, req;
    logic [9:0]  prog_ctr;
    logic        host_we, core_we, mem_we, host_gnt;
    logic [7:0]  host_addr, host_wdat, host_rdat, core_addr, core_wdat;
    logic [7:0]  mem_addr, mem_wdat, mem_rdat;
    logic        core_rst, busy, done, timeout;
    logic [15:0] cycle_cnt;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdat;
    assign mem_rdat = mem[mem_addr];

    run_ctrl #(.D(10), .RST_CYC(RST_CYC), .WDOG_LIMIT(16'(LIMIT))) dut (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(prog_ctr),
        .host_we(host_we), .host_addr(host_addr), .host_wdat(host_wdat),
        .host_rdat(host_rdat), .host_gnt(host_gnt),
        .core_we(core_we), .core_addr(core_addr), .core_wdat(core_wdat),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
        .core_rst(core_rst), .busy(busy), .done(done), .timeout(timeout),
        .cycle_cnt(cycle_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        host_we = 1'b1; host_addr = a; host_wdat = d;
        tick();
        host_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic host_read(input logic [7:0] a);
        host_addr = a;
        #1;
        check($sformatf("readback[%0h]", a), host_rdat, ref_mem[a]);
    endtask

    // From IDLE: raise req and walk through START, ending in the first RUN cycle.
    task automatic launch(input bit drop);
        int k;
        req = 1'b1; host_we = 1'b0;
        tick();
        check("start_busy", busy, 1);
        check("start_gnt", host_gnt, 0);
        check("start_done", done, 0);
        check("start_cnt_clr", cycle_cnt, 0);
        check("start_to_clr", timeout, 0);
        if (drop) req = 1'b0;
        host_we = 1'b1; host_addr = 8'h10; host_wdat = 8'hEE;
        #1;
        check("start_we_gated", mem_we, 0);
        check("start_addr_host", mem_addr, 8'h10);
        k = 0;
        while (core_rst && k < 20) begin
            k++;
            tick();
        end
        check("core_rst_cycles", k, RST_CYC);
        check("run_busy", busy, 1);
        host_we = 1'b0;
    endtask

    // Run-level model: the run lasts until halt, or until the watchdog limit when that comes first.
    task automatic run_phase(input int halt_at, input int abort_at);
        int  exp_end;
        bit  exp_to;
        bit  ended;
        exp_to = 1'b0;
        if (abort_at > 0) exp_end = abort_at;
        else if (WDOG && (halt_at == 0 || halt_at > LIMIT)) begin
            exp_end = LIMIT; exp_to = 1'b1;
        end else exp_end = halt_at;
        ended = 1'b0;
        for (int i = 1; i <= 400 && !ended; i++) begin
            prog_ctr  = (i == halt_at) ? 10'd128 : 10'($urandom_range(0, 127));
            core_we   = 1'($urandom_range(0, 1));
            core_addr = 8'($urandom_range(32, 255));
            core_wdat = 8'($urandom);
            host_we = 1'b1; host_addr = 8'h10; host_wdat = 8'h5A;
            #1;
            if (i <= 4) begin
                check("run_mem_we", mem_we, core_we);
                check("run_mem_addr", mem_addr, core_addr);
                check("run_gnt", host_gnt, 0);
            end
            if (core_we) ref_mem[core_addr] = core_wdat;
            tick();
            if (i == exp_end) ended = 1'b1;
            else if (done !== 1'b0) check("done_early", done, 0);
        end
        host_we = 1'b0; core_we = 1'b0; prog_ctr = '0;
        check("run_ended", ended, 1);
        check("end_cnt", cycle_cnt, exp_end);
        if (abort_at == 0) begin
            check("end_done", done, 1);
            check("end_timeout", timeout, exp_to);
            check("end_core_rst", core_rst, 1);
            check("end_busy", busy, 0);
            check("end_gnt", host_gnt, 1);
        end
    endtask

    // In DONE: optionally hold req to confirm no restart, then release and return to IDLE.
    task automatic finish_run(input logic [15:0] exp_cnt);
        if (req) begin
            tick(); tick();
            check("hold_done", done, 1);
            check("hold_cnt", cycle_cnt, exp_cnt);
            check("hold_busy", busy, 0);
            req = 1'b0;
        end
        tick();
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_gnt", host_gnt, 1);
        check("idle_core_rst", core_rst, 1);
    endtask

    initial begin
        int h;
        bit d;
        reset = 1'b0; req = 1'b0; prog_ctr = '0;
        host_we = 1'b0; host_addr = '0; host_wdat = '0;
        core_we = 1'b0; core_addr = '0; core_wdat = '0;
        tick(); tick();
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_gnt", host_gnt, 1);
        reset = 1'b1;
        tick();

        // Preload, 50-cycle run, host writes during RUN dropped
        host_write(8'h10, 8'hA5);
        for (int i = 0; i < 4; i++) host_write(8'($urandom_range(32, 255)), 8'($urandom));
        host_read(8'h10);
        launch(1'b0);
        run_phase(50, 0);
        finish_run(16'd50);
        host_read(8'h10);
        for (int i = 0; i < 4; i++) host_read(8'($urandom_range(32, 255)));

        // Reset in the middle of a run
        launch(1'b0);
        run_phase(0, 20);
        req = 1'b0; reset = 1'b0;
        tick();
        check("abort_core_rst", core_rst, 1);
        check("abort_cnt", cycle_cnt, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_gnt", host_gnt, 1);
        reset = 1'b1;
        tick();

        // Watchdog expiry (or, without it, a run beyond the limit)
        launch(1'b0);
        if (WDOG) begin
            run_phase(0, 0);
            finish_run(16'(LIMIT));
        end else begin
            run_phase(130, 0);
            finish_run(16'd130);
        end

        // Halt on the same cycle the watchdog would fire
        launch(1'b0);
        run_phase(LIMIT, 0);
        finish_run(16'(LIMIT));

        // req dropped during START still completes
        launch(1'b1);
        run_phase(17, 0);
        finish_run(16'd17);

        // Randomized runs
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 3; i++) host_write(8'($urandom_range(0, 255)), 8'($urandom));
            h = $urandom_range(1, 80);
            d = 1'($urandom_range(0, 1));
            launch(d);
            run_phase(h, 0);
            finish_run(16'(h));
            for (int i = 0; i < 3; i++) host_read(8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
